// File: rtl/tone_source_if.sv
// Sample-stream bus between the tone source (master) and its controller/receiver (slave).
interface tone_source_if;
  // Handshake: data_valid marks one sample per asserted cycle. There is no ready; the
  // receiver must accept every strobed sample. start is a one-cycle request honoured only
  // while the source is idle; stop is a level that ends transmission at a frame boundary.
  logic               start;
  logic               stop;
  logic [3:0]         tone_sel;
  logic [1:0]         amp_shift;
  logic [7:0]         num_frames;
  logic               data_valid;
  logic signed [15:0] data;
  logic               frame_done;
  logic               busy;
  logic [1:0]         state_dbg;

  modport master (
    input  start, stop, tone_sel, amp_shift, num_frames,
    output data_valid, data, frame_done, busy, state_dbg
  );

  modport slave (
    output start, stop, tone_sel, amp_shift, num_frames,
    input  data_valid, data, frame_done, busy, state_dbg
  );
endinterface

// File: rtl/tone_source.sv
// Test-tone transmitter: 16-sample frames of a sine at bin tone_sel, optional inter-frame gap.
// Optional dither (LFSR noise added after the amplitude shift) is enabled by defining DITHER_EN.
module tone_source #(
  parameter int          GAP_CYC = 0,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  tone_source_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [3:0]         n_q, n_d;
  logic [3:0]         tone_q, tone_d;
  logic [1:0]         amp_q, amp_d;
  logic [7:0]         nf_q, nf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        gap_q, gap_d;
  logic               dv_q, dv_d;
  logic               fd_q, fd_d;
  logic signed [15:0] data_q, data_d;

  logic               more;
  logic               emit;
  logic [3:0]         p;
  logic [2:0]         idx;
  logic [14:0]        mag;
  logic signed [15:0] mag_s;
  logic signed [15:0] s;
  logic signed [15:0] shifted;
  logic signed [15:0] sample;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    tone_d  = tone_q;
    amp_d   = amp_q;
    nf_d    = nf_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    emit    = 1'b0;
    // cnt_q counts frames already finished, so this frame makes cnt_q+1
    more    = (nf_q == 8'd0) || (({1'b0, cnt_q} + 9'd1) < {1'b0, nf_q});
    case (state_q)
      IDLE: begin
        if (bus.start && !dv_q) begin
          state_d = RUN;
          n_d     = 4'd0;
          tone_d  = bus.tone_sel;
          amp_d   = bus.amp_shift;
          nf_d    = bus.num_frames;
          cnt_d   = 8'd0;
        end
      end
      RUN: begin
        emit = 1'b1;
        n_d  = n_q + 4'd1;
        if (n_q == 4'd15) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (bus.stop || !more) begin
            state_d = IDLE;
          end else if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = 16'd0;
          end
        end
      end
      GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (gap_q == 16'(GAP_CYC - 1)) begin
          state_d = RUN;
          n_d     = 4'd0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Quarter-wave lookup: p[2] mirrors the index, p[3] negates the half-wave.
  always_comb begin
    p   = tone_q * n_q;
    idx = p[2] ? (3'd4 - {1'b0, p[1:0]}) : {1'b0, p[1:0]};
    case (idx)
      3'd0:    mag = 15'd0;
      3'd1:    mag = 15'd6270;
      3'd2:    mag = 15'd11585;
      3'd3:    mag = 15'd15137;
      default: mag = 15'd16384;
    endcase
    mag_s   = $signed({1'b0, mag});
    s       = p[3] ? -mag_s : mag_s;
    shifted = s >>> amp_q;
  end

`ifdef DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [16:0] sum;

  always_comb begin
    sum    = {shifted[15], shifted} + {{14{lfsr_q[2]}}, lfsr_q[2:0]};
    lfsr_d = lfsr_q;
    if (emit) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (sum[16:15])
      2'b01:   sample = 16'sh7FFF;
      2'b10:   sample = 16'sh8000;
      default: sample = $signed(sum[15:0]);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign sample = shifted;
`endif

  always_comb begin
    dv_d   = emit;
    data_d = emit ? sample : 16'sd0;
    fd_d   = emit && (n_q == 4'd15);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= 4'd0;
      tone_q  <= 4'd0;
      amp_q   <= 2'd0;
      nf_q    <= 8'd0;
      cnt_q   <= 8'd0;
      gap_q   <= 16'd0;
      dv_q    <= 1'b0;
      fd_q    <= 1'b0;
      data_q  <= 16'sd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      tone_q  <= tone_d;
      amp_q   <= amp_d;
      nf_q    <= nf_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      dv_q    <= dv_d;
      fd_q    <= fd_d;
      data_q  <= data_d;
    end
  end

  // busy stays up through the cycle that shows the final sample.
  assign bus.busy       = (state_q != IDLE) || dv_q;
  assign bus.data_valid = dv_q;
  assign bus.data       = data_q;
  assign bus.frame_done = fd_q;
  assign bus.state_dbg  = state_q;
endmodule
